// File: rtl/deserializer_rx.sv
// MSB-first serial-to-parallel receiver framed by an active-low chip select.
// Completed words are held on p_data under a valid/ready handshake, with overrun and frame-error pulses.
module deserializer_rx #(
    parameter int bus_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 enable,
    input  logic                 s_data,
    input  logic                 data_ready,
    output logic [bus_width-1:0] p_data,
    output logic                 data_valid,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int CNT_W = (bus_width > 1) ? $clog2(bus_width) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(bus_width - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [bus_width-1:0] shift_q, shift_d;
    logic [bus_width-1:0] p_data_q, p_data_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;

    logic                 sample;
    logic                 complete;
    logic [bus_width-1:0] word;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_n) state_d = SHIFT;
            SHIFT:   if (cs_n)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        shift_d     = shift_q;
        count_d     = count_q;
        p_data_d    = p_data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        sample   = enable && !cs_n;
        word     = {shift_q[bus_width-2:0], s_data};
        complete = sample && (count_q == LAST);

        // Chip-select release wins over a coincident strobe: the bit is dropped with the partial word.
        if (cs_n) begin
            frame_err_d = (state_q == SHIFT) && (count_q != '0);
            shift_d     = '0;
            count_d     = '0;
        end else if (sample) begin
            shift_d = word;
            count_d = complete ? '0 : count_q + CNT_W'(1);
        end

        if (complete) begin
            if (!valid_q || data_ready) begin
                p_data_d = word;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            count_q     <= '0;
            p_data_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            count_q     <= count_d;
            p_data_q    <= p_data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Self-checking bench for deserializer_rx: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a bit-accumulating reference model.
module tb_deserializer_rx;

    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic          enable;
    logic          s_data;
    logic          data_ready;
    logic [BW-1:0] p_data;
    logic          data_valid;
    logic          overrun;
    logic          frame_err;

    int checks   = 0;
    int failures = 0;

    deserializer_rx #(.bus_width(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .enable     (enable),
        .s_data     (s_data),
        .data_ready (data_ready),
        .p_data     (p_data),
        .data_valid (data_valid),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          cs_n;
        bit          en;
        bit          sd;
        bit          rdy;
        logic [7:0]  pd;
        bit          v;
        bit          ov;
        bit          fe;
    } vec_t;

    vec_t vecs[$];

    // Reference model: bits collected as an integer, completed words handed to a one-deep holding slot.
    int m_bits;
    int m_acc;
    int m_pdata;
    bit m_valid;
    bit m_ovr;
    bit m_ferr;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit r, bit c, bit e, bit d, bit rdy);
        rst        = r;
        cs_n       = c;
        enable     = e;
        s_data     = d;
        data_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b, bit rdy);
        for (int i = 7; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, b[i], rdy);
    endtask

    function automatic void add(bit r, bit c, bit e, bit d, bit rdy,
                                logic [7:0] pd, bit v, bit ov, bit fe);
        vecs.push_back('{r, c, e, d, rdy, pd, v, ov, fe});
    endfunction

    function automatic void model_step(bit r, bit c, bit e, bit d, bit rdy);
        bit done;
        int word;
        done = 1'b0;
        word = 0;
        if (r) begin
            m_bits = 0; m_acc = 0; m_pdata = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
            return;
        end
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (c) begin
            m_ferr = (m_bits != 0);
            m_bits = 0;
            m_acc  = 0;
        end else if (e) begin
            m_acc  = ((m_acc * 2) + int'(d)) % (1 << BW);
            m_bits = m_bits + 1;
            if (m_bits == BW) begin
                done   = 1'b1;
                word   = m_acc;
                m_bits = 0;
                m_acc  = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_pdata = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endfunction

    initial begin
        logic [7:0] a5, b11, b22, w;
        logic [15:0] pair;
        bit ov_seen;

        rst = 1'b1; cs_n = 1'b1; enable = 1'b0; s_data = 1'b0; data_ready = 1'b0;

        // Vector table: reset, 0xA5 capture, consume, then 0x11 held while 0x22 overruns.
        a5  = 8'hA5;
        b11 = 8'h11;
        b22 = 8'h22;
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, a5[7-i], 0, (i == 7) ? 8'hA5 : 8'h00, i == 7, 0, 0);
        add(0, 1, 0, 0, 1, 8'hA5, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, b11[7-i], 0, (i == 7) ? 8'h11 : 8'hA5, i == 7, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, b22[7-i], 0, 8'h11, 1, i == 7, 0);
        add(0, 0, 0, 0, 0, 8'h11, 1, 0, 0);
        add(0, 1, 0, 0, 1, 8'h11, 0, 0, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].cs_n, vecs[k].en, vecs[k].sd, vecs[k].rdy);
            check($sformatf("vec%0d_pdata", k), 32'(p_data), 32'(vecs[k].pd));
            check($sformatf("vec%0d_valid", k), 32'(data_valid), 32'(vecs[k].v));
            check($sformatf("vec%0d_overrun", k), 32'(overrun), 32'(vecs[k].ov));
            check($sformatf("vec%0d_frame_err", k), 32'(frame_err), 32'(vecs[k].fe));
        end

        // Back-to-back words with the consumer always ready.
        pair = 16'h3CC3;
        ov_seen = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            drive(0, 0, 1, pair[i], 1);
            ov_seen |= overrun;
            if (i == 8) begin
                check("b2b_first_pdata", 32'(p_data), 32'h3C);
                check("b2b_first_valid", 32'(data_valid), 32'd1);
            end
            if (i == 7) begin
                check("b2b_consumed_valid", 32'(data_valid), 32'd0);
                check("b2b_consumed_pdata", 32'(p_data), 32'h3C);
            end
            if (i == 0) begin
                check("b2b_second_pdata", 32'(p_data), 32'hC3);
                check("b2b_second_valid", 32'(data_valid), 32'd1);
            end
        end
        drive(0, 0, 0, 0, 1);
        check("b2b_drain_valid", 32'(data_valid), 32'd0);
        check("b2b_no_overrun", 32'(ov_seen), 32'd0);

        // Simultaneous consume and load on the completing edge.
        send_byte(8'h81, 0);
        check("swap_first_pdata", 32'(p_data), 32'h81);
        w = 8'h7E;
        for (int i = 7; i >= 0; i--) drive(0, 0, 1, w[i], i == 0);
        check("swap_pdata", 32'(p_data), 32'h7E);
        check("swap_valid", 32'(data_valid), 32'd1);
        check("swap_no_overrun", 32'(overrun), 32'd0);
        drive(0, 1, 0, 0, 1);
        check("swap_drain_valid", 32'(data_valid), 32'd0);

        // Aborted frames, including release coincident with a strobe.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0);
        drive(0, 1, 0, 0, 0);
        check("abort_frame_err", 32'(frame_err), 32'd1);
        check("abort_valid", 32'(data_valid), 32'd0);
        drive(0, 1, 0, 0, 0);
        check("abort_pulse_end", 32'(frame_err), 32'd0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 1, 0);
        check("abort_with_enable", 32'(frame_err), 32'd1);
        send_byte(8'h0F, 0);
        check("after_abort_pdata", 32'(p_data), 32'h0F);
        check("after_abort_valid", 32'(data_valid), 32'd1);
        drive(0, 1, 0, 0, 1);

        // Sparse strobes with noise on s_data between them.
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            drive(0, 0, 0, ~w[i], 0);
            drive(0, 0, 0, 1'($urandom), 0);
            drive(0, 0, 1, w[i], 0);
            if (i == 1) check("sparse_not_yet", 32'(data_valid), 32'd0);
        end
        check("sparse_pdata", 32'(p_data), 32'h5A);
        check("sparse_valid", 32'(data_valid), 32'd1);
        drive(0, 1, 0, 0, 1);

        // Reset mid-word with a pending word.
        send_byte(8'h99, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0);
        drive(1, 0, 1, 1, 0);
        check("rst_pdata", 32'(p_data), 32'h00);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        drive(0, 1, 0, 0, 0);
        check("rst_no_frame_err", 32'(frame_err), 32'd0);
        send_byte(8'hFF, 0);
        check("post_rst_pdata", 32'(p_data), 32'hFF);
        check("post_rst_valid", 32'(data_valid), 32'd1);

        // Randomized traffic against the reference model.
        model_step(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, c, e, d, rdy;
            r   = ($urandom_range(0, 299) == 0);
            c   = ($urandom_range(0, 24) == 0);
            e   = ($urandom_range(0, 9) < 7);
            d   = 1'($urandom);
            rdy = ($urandom_range(0, 9) < 4);
            model_step(r, c, e, d, rdy);
            drive(r, c, e, d, rdy);
            check($sformatf("rand%0d_pdata", n), 32'(p_data), 32'(m_pdata));
            check($sformatf("rand%0d_valid", n), 32'(data_valid), 32'(m_valid));
            check($sformatf("rand%0d_overrun", n), 32'(overrun), 32'(m_ovr));
            check($sformatf("rand%0d_frame_err", n), 32'(frame_err), 32'(m_ferr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
